// File: rtl/fp_operand_unpack_if.sv
// Stream bundle for fp_operand_unpack: packed binary32 words in, decoded sign/exponent/significand plus class flags out.
interface fp_operand_unpack_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned SIG_W  = 24;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic [SIG_W-1:0]  significand;
  logic              is_zero;
  logic              is_denorm;
  logic              is_inf;
  logic              is_nan;
  logic              is_qnan;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, sign, exponent, significand,
           is_zero, is_denorm, is_inf, is_nan, is_qnan
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, sign, exponent, significand,
           is_zero, is_denorm, is_inf, is_nan, is_qnan
  );
endinterface

// File: rtl/fp_operand_unpack.sv
// Two-stage binary32 operand unpacker: S1 holds the raw word, S2 the decoded sign/exponent/significand and class.
// Optional feature macro FP_UNPACK_DENORM_EN: keep denormals (exponent 1, no hidden bit) instead of flushing to zero.
module fp_operand_unpack (
  input  logic                clock,
  input  logic                resetn,
  fp_operand_unpack_if.slave  bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;

  logic              s1_valid;
  logic [WORD_W-1:0] s1_word;
  logic              s2_advance;
  logic              s1_load;

  logic              d_sign;
  logic [EXP_W-1:0]  d_exp;
  logic [SIG_W-1:0]  d_sig;
  logic              d_zero;
  logic              d_denorm;
  logic              d_inf;
  logic              d_nan;
  logic              d_qnan;

  logic [EXP_W-1:0]  raw_exp;
  logic [FRAC_W-1:0] raw_frac;

  // S2 may take S1 whenever it is empty or being drained this edge
  assign s2_advance   = s1_valid && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_advance;
  assign s1_load      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_word  <= bus.in_word;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  assign raw_exp  = s1_word[WORD_W-2 -: EXP_W];
  assign raw_frac = s1_word[FRAC_W-1:0];

  // Field split and classification of the word held in S1
  always_comb begin
    d_sign   = s1_word[WORD_W-1];
    d_exp    = raw_exp;
    d_sig    = {1'b1, raw_frac};
    d_zero   = 1'b0;
    d_denorm = 1'b0;
    d_inf    = 1'b0;
    d_nan    = 1'b0;
    d_qnan   = 1'b0;
    if (raw_exp == '0) begin
      if (raw_frac == '0) begin
        d_zero = 1'b1;
        d_exp  = '0;
        d_sig  = '0;
      end else begin
`ifdef FP_UNPACK_DENORM_EN
        d_denorm = 1'b1;
        d_exp    = EXP_W'(1);
        d_sig    = {1'b0, raw_frac};
`else
        d_zero = 1'b1;
        d_exp  = '0;
        d_sig  = '0;
`endif
      end
    end else if (raw_exp == '1) begin
      if (raw_frac == '0) begin
        d_inf = 1'b1;
      end else begin
        d_nan  = 1'b1;
        d_qnan = raw_frac[FRAC_W-1];
      end
    end
  end

  // Output stage: fields only change on an advance, so they hold under backpressure
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid   <= 1'b0;
      bus.sign        <= 1'b0;
      bus.exponent    <= '0;
      bus.significand <= '0;
      bus.is_zero     <= 1'b0;
      bus.is_denorm   <= 1'b0;
      bus.is_inf      <= 1'b0;
      bus.is_nan      <= 1'b0;
      bus.is_qnan     <= 1'b0;
    end else if (s2_advance) begin
      bus.out_valid   <= 1'b1;
      bus.sign        <= d_sign;
      bus.exponent    <= d_exp;
      bus.significand <= d_sig;
      bus.is_zero     <= d_zero;
      bus.is_denorm   <= d_denorm;
      bus.is_inf      <= d_inf;
      bus.is_nan      <= d_nan;
      bus.is_qnan     <= d_qnan;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed self-checking bench for fp_operand_unpack; expected values are hand-derived from the binary32 format.
module tb_fp_operand_unpack;
  logic clock;
  logic resetn;
  int   n_vec;
  int   n_err;

  fp_operand_unpack_if bus ();

  fp_operand_unpack dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] flags();
    return {bus.is_zero, bus.is_denorm, bus.is_inf, bus.is_nan, bus.is_qnan};
  endfunction

  // Offers one word with out_ready=1 and leaves the bench at the negedge where it is visible on the outputs
  task automatic send_one(input logic [31:0] w, output logic rdy, output logic early);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_word   = w;
    bus.out_ready = 1'b1;
    #1 rdy = bus.in_ready;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_word  = 32'hDEAD_BEEF;
    early = bus.out_valid;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== 38'h0) begin
      n_err++; $display("FAIL reset_fields got %b %h %h %b want all zero", bus.sign, bus.exponent, bus.significand, flags());
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_normal();
    logic rdy, early;
    send_one(32'h3F80_0000, rdy, early);
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL normal_in_ready got %b want 1", rdy); end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL normal_latency_early got %b want 0", early); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL normal_out_valid got %b want 1", bus.out_valid); end
    n_vec++; if ({bus.sign, bus.exponent, bus.significand} !== {1'b0, 8'h7F, 24'h80_0000}) begin
      n_err++; $display("FAIL normal_fields got %b %h %h want 0 7f 800000", bus.sign, bus.exponent, bus.significand);
    end
    n_vec++; if (flags() !== 5'b00000) begin n_err++; $display("FAIL normal_flags got %b want 00000", flags()); end
    @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL normal_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_specials();
    logic rdy, early;
    send_one(32'hFF80_0000, rdy, early);
    n_vec++; if ({bus.out_valid, bus.sign, bus.exponent, bus.significand, flags()} !== {1'b1, 1'b1, 8'hFF, 24'h80_0000, 5'b00100}) begin
      n_err++; $display("FAIL neg_inf got v=%b s=%b e=%h m=%h f=%b want 1 1 ff 800000 00100", bus.out_valid, bus.sign, bus.exponent, bus.significand, flags());
    end
    send_one(32'h7FC0_0001, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== {1'b0, 8'hFF, 24'hC0_0001, 5'b00011}) begin
      n_err++; $display("FAIL qnan got s=%b e=%h m=%h f=%b want 0 ff c00001 00011", bus.sign, bus.exponent, bus.significand, flags());
    end
    send_one(32'h7F80_0001, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== {1'b0, 8'hFF, 24'h80_0001, 5'b00010}) begin
      n_err++; $display("FAIL snan got s=%b e=%h m=%h f=%b want 0 ff 800001 00010", bus.sign, bus.exponent, bus.significand, flags());
    end
    send_one(32'h8000_0000, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== {1'b1, 8'h00, 24'h00_0000, 5'b10000}) begin
      n_err++; $display("FAIL neg_zero got s=%b e=%h m=%h f=%b want 1 00 000000 10000", bus.sign, bus.exponent, bus.significand, flags());
    end
    send_one(32'h7F7F_FFFF, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== {1'b0, 8'hFE, 24'hFF_FFFF, 5'b00000}) begin
      n_err++; $display("FAIL max_normal got s=%b e=%h m=%h f=%b want 0 fe ffffff 00000", bus.sign, bus.exponent, bus.significand, flags());
    end
  endtask

  task automatic test_denorm();
    logic rdy, early;
    logic [33:0] want_a, want_b;
`ifdef FP_UNPACK_DENORM_EN
    want_a = {1'b0, 8'h01, 24'h00_0001, 1'b0};
    want_b = {1'b1, 8'h01, 24'h40_0000, 1'b0};
`else
    want_a = {1'b0, 8'h00, 24'h00_0000, 1'b1};
    want_b = {1'b1, 8'h00, 24'h00_0000, 1'b1};
`endif
    send_one(32'h0000_0001, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, bus.is_zero} !== want_a) begin
      n_err++; $display("FAIL denorm_min got %b %h %h z=%b want %h", bus.sign, bus.exponent, bus.significand, bus.is_zero, want_a);
    end
    n_vec++; if ({bus.is_denorm, bus.is_inf, bus.is_nan, bus.is_qnan} !== {~want_a[0], 3'b000}) begin
      n_err++; $display("FAIL denorm_min_flags got %b want %b", flags(), {want_a[0], ~want_a[0], 3'b000});
    end
    send_one(32'h8040_0000, rdy, early);
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, bus.is_zero} !== want_b) begin
      n_err++; $display("FAIL denorm_neg got %b %h %h z=%b want %h", bus.sign, bus.exponent, bus.significand, bus.is_zero, want_b);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h4000_0000;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept0 got %b want 1", bus.in_ready); end
    @(negedge clock);
    bus.in_word = 32'h4040_0000;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1 got %b want 1", bus.in_ready); end
    @(negedge clock);
    bus.in_word = 32'h4080_0000;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", bus.in_ready); end
    n_vec++; if ({bus.out_valid, bus.exponent, bus.significand} !== {1'b1, 8'h80, 24'h80_0000}) begin
      n_err++; $display("FAIL bp_head got v=%b e=%h m=%h want 1 80 800000", bus.out_valid, bus.exponent, bus.significand);
    end
    @(negedge clock);
    n_vec++; if ({bus.in_ready, bus.out_valid, bus.exponent, bus.significand} !== {1'b0, 1'b1, 8'h80, 24'h80_0000}) begin
      n_err++; $display("FAIL bp_hold got r=%b v=%b e=%h m=%h want 0 1 80 800000", bus.in_ready, bus.out_valid, bus.exponent, bus.significand);
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_vec++; if ({bus.out_valid, bus.exponent, bus.significand} !== {1'b1, 8'h80, 24'hC0_0000}) begin
      n_err++; $display("FAIL bp_second got v=%b e=%h m=%h want 1 80 c00000", bus.out_valid, bus.exponent, bus.significand);
    end
    @(negedge clock);
    n_vec++; if ({bus.out_valid, bus.exponent, bus.significand} !== {1'b1, 8'h81, 24'h80_0000}) begin
      n_err++; $display("FAIL bp_third got v=%b e=%h m=%h want 1 81 800000", bus.out_valid, bus.exponent, bus.significand);
    end
    @(negedge clock);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int bad_rdy, bad_out;
    bad_rdy = 0;
    bad_out = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      bus.out_ready = 1'b1;
      if (i < 16) begin
        bus.in_valid = 1'b1;
        bus.in_word  = {i[0], 8'(8'h70 + i), 23'(i * 23'h01357 + 1)};
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (i < 16 && bus.in_ready !== 1'b1) bad_rdy++;
      if (i >= 2) begin
        int k;
        k = i - 2;
        if ({bus.out_valid, bus.sign, bus.exponent, bus.significand} !==
            {1'b1, k[0], 8'(8'h70 + k), 1'b1, 23'(k * 23'h01357 + 1)}) begin
          bad_out++;
          $display("FAIL stream_word%0d got v=%b s=%b e=%h m=%h", k, bus.out_valid, bus.sign, bus.exponent, bus.significand);
        end
      end
    end
    n_vec++; if (bad_rdy !== 0) begin n_err++; $display("FAIL stream_in_ready got %0d stalls want 0", bad_rdy); end
    n_vec++; if (bad_out !== 0) begin n_err++; $display("FAIL stream_outputs got %0d bad cycles want 0", bad_out); end
    @(negedge clock);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random_backpressure();
    logic [31:0] q[$];
    logic [32:0] got, want;
    logic [31:0] w;
    int acc_n, del_n, bad;
    acc_n = 0;
    del_n = 0;
    bad   = 0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clock);
      w = {1'(c % 3 == 0), 8'($urandom_range(1, 254)), 23'($urandom)};
      bus.in_valid  = (c < 240) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_word   = w;
      bus.out_ready = (c < 240) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        del_n++;
        got = {bus.sign, bus.exponent, bus.significand};
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra got %h with empty scoreboard", got);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          want = {e[31], e[30:23], 1'b1, e[22:0]};
          if (got !== want) begin
            bad++;
            $display("FAIL rand_order got %h want %h", got, want);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_n++;
        q.push_back(w);
      end
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rand_scoreboard got %0d errors want 0", bad); end
    n_vec++; if (del_n !== acc_n || q.size() != 0) begin
      n_err++; $display("FAIL rand_count got %0d delivered want %0d accepted", del_n, acc_n);
    end
  endtask

  task automatic test_reset_midstream();
    logic rdy, early;
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'hC0A0_0000;
    @(negedge clock);
    bus.in_word   = 32'h7F80_0000;
    @(negedge clock);
    bus.in_valid  = 1'b0;
    #1;
    n_vec++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
      n_err++; $display("FAIL rst_full got r=%b v=%b want 0 1", bus.in_ready, bus.out_valid);
    end
    resetn = 1'b0;
    #1;
    n_vec++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++; $display("FAIL rst_async got v=%b r=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    n_vec++; if ({bus.sign, bus.exponent, bus.significand, flags()} !== 38'h0) begin
      n_err++; $display("FAIL rst_async_fields got %b %h %h %b want zero", bus.sign, bus.exponent, bus.significand, flags());
    end
    @(negedge clock);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    n_vec++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++; $display("FAIL rst_no_leftover got v=%b r=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    send_one(32'h3F80_0000, rdy, early);
    n_vec++; if ({rdy, early, bus.out_valid, bus.sign, bus.exponent, bus.significand, flags()} !== {3'b101, 1'b0, 8'h7F, 24'h80_0000, 5'b0}) begin
      n_err++; $display("FAIL rst_first_word got r=%b e=%b v=%b s=%b e=%h m=%h f=%b", rdy, early, bus.out_valid, bus.sign, bus.exponent, bus.significand, flags());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_normal();
    test_specials();
    test_denorm();
    test_backpressure();
    test_back_to_back();
    test_random_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
